// File: rtl/decoder_pkg.sv
// Shared types and the one-hot decode rule for decoder_nx2n_pipe.
// Words are built at the widest legal size (2^8) and sliced by the user.
package decoder_pkg;

  localparam int ERR_CNT_W = 8;
  localparam int MAX_OUT   = 256;

  typedef struct packed {
    logic [MAX_OUT-1:0] word;
    logic               err;
  } dec_entry_t;

  // Bits at or above width are don't-care for the caller.
  function automatic dec_entry_t onehot_decode(input logic [7:0] sel,
                                               input logic       enable,
                                               input int         width,
                                               input logic       act_high);
    dec_entry_t e;
    e.word = '0;
    e.err  = 1'b0;
    if (enable) begin
      if (int'(sel) < width) e.word[sel] = 1'b1;
      else                   e.err       = 1'b1;
    end
    if (!act_high) e.word = ~e.word;
    return e;
  endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready is registered so it never
// depends combinationally on out_ready.
module dec_skid_buf #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic [1:0]        count;
  logic [1:0]        count_next;
  logic [DATA_W-1:0] main_reg;
  logic [DATA_W-1:0] skid_reg;
  logic              push;
  logic              pop;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = main_reg;

  always_comb begin
    count_next = count + {1'b0, push} - {1'b0, pop};
  end

  // Main always feeds the output; skid only fills when main is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= 2'd0;
      in_ready <= 1'b0;
      main_reg <= RESET_DATA;
      skid_reg <= RESET_DATA;
    end else begin
      count    <= count_next;
      in_ready <= (count_next < 2'd2);
      if (pop && count == 2'd2) begin
        main_reg <= skid_reg;
      end else if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
        main_reg <= in_data;
      end
      if (push && count == 2'd1 && !pop) begin
        skid_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/decoder_nx2n_pipe.sv
// Pipelined N-to-2^N one-hot decoder with valid/ready skid buffering.
// Optional error flag/counter ports enabled by DECODER_ERR_CNT_EN.
module decoder_nx2n_pipe
  import decoder_pkg::*;
#(
  parameter int SEL_W    = 3,
  parameter int NUM_OUT  = 8,
  parameter bit ACT_HIGH = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_onehot
`ifdef DECODER_ERR_CNT_EN
  ,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam logic [NUM_OUT-1:0] IDLE_WORD = ACT_HIGH ? '0 : '1;

  logic [7:0] sel_ext;
  dec_entry_t dec;

  assign sel_ext = 8'(in_sel);
  assign dec     = onehot_decode(sel_ext, in_en, NUM_OUT, ACT_HIGH);

  if (NUM_OUT < MAX_OUT) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^dec.word[MAX_OUT-1:NUM_OUT];
  end

`ifdef DECODER_ERR_CNT_EN
  localparam int DATA_W = NUM_OUT + 1;

  logic [DATA_W-1:0] buf_in;
  logic [DATA_W-1:0] buf_out;

  assign buf_in                = {dec.word[NUM_OUT-1:0], dec.err};
  assign {out_onehot, out_err} = buf_out;

  // Counts accepted out-of-range codes, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (in_valid && in_ready && dec.err && err_cnt != '1) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  dec_skid_buf #(
    .DATA_W     (DATA_W),
    .RESET_DATA ({IDLE_WORD, 1'b0})
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (buf_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );
`else
  logic unused_err;
  assign unused_err = dec.err;

  dec_skid_buf #(
    .DATA_W     (NUM_OUT),
    .RESET_DATA (IDLE_WORD)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec.word[NUM_OUT-1:0]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_onehot)
  );
`endif

endmodule

// File: tb/tb_decoder_nx2n_pipe.sv
// Randomised self-checking bench for decoder_nx2n_pipe: an 8-output
// active-high instance and a 5-output active-low instance.
module tb_decoder_nx2n_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_in_valid, a_in_ready, a_in_en, a_out_valid, a_out_ready;
  logic [2:0] a_in_sel;
  logic [7:0] a_out_onehot;
  logic       b_in_valid, b_in_ready, b_in_en, b_out_valid, b_out_ready;
  logic [2:0] b_in_sel;
  logic [4:0] b_out_onehot;
`ifdef DECODER_ERR_CNT_EN
  logic       a_out_err, b_out_err;
  logic [7:0] a_err_cnt, b_err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] qa[$];
  logic       a_ready;
  logic       b_ready, b_exp_valid, b_exp_err;
  logic [4:0] b_exp_word;
  int         b_exp_cnt;

  decoder_nx2n_pipe #(.SEL_W(3), .NUM_OUT(8), .ACT_HIGH(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sel(a_in_sel), .in_en(a_in_en),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_onehot(a_out_onehot)
`ifdef DECODER_ERR_CNT_EN
    , .out_err(a_out_err), .err_cnt(a_err_cnt)
`endif
  );

  decoder_nx2n_pipe #(.SEL_W(3), .NUM_OUT(5), .ACT_HIGH(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sel(b_in_sel), .in_en(b_in_en),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_onehot(b_out_onehot)
`ifdef DECODER_ERR_CNT_EN
    , .out_err(b_out_err), .err_cnt(b_err_cnt)
`endif
  );

  // Decode rule in plain arithmetic: selected bit weight, or none.
  function automatic logic [7:0] model_word(int sel, bit en, int n, bit act_high);
    int v;
    v = (en && sel < n) ? (1 << sel) : 0;
    if (!act_high) v = ((1 << n) - 1) - v;
    return 8'(v);
  endfunction

  task automatic idle_inputs();
    a_in_valid = 1'b0; a_in_sel = 3'd0; a_in_en = 1'b1; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_sel = 3'd0; b_in_en = 1'b1; b_out_ready = 1'b1;
  endtask

  // One clock edge: update both reference models, then settle past the edge.
  task automatic advance();
    bit pop, acc, err;
    @(posedge clk);
    if (!rst_n) begin
      qa.delete();
      a_ready     = 1'b0;
      b_ready     = 1'b0;
      b_exp_valid = 1'b0;
      b_exp_err   = 1'b0;
      b_exp_word  = 5'h1F;
      b_exp_cnt   = 0;
    end else begin
      pop = (qa.size() != 0) && a_out_ready;
      acc = a_in_valid && a_ready;
      if (pop) void'(qa.pop_front());
      if (acc) qa.push_back(model_word(a_in_sel, a_in_en, 8, 1'b1));
      a_ready = (qa.size() < 2);
      acc = b_in_valid && b_ready;
      b_exp_valid = acc;
      if (acc) begin
        err        = b_in_en && (b_in_sel >= 3'd5);
        b_exp_word = 5'(model_word(b_in_sel, b_in_en, 5, 1'b0));
        b_exp_err  = err;
        if (err && b_exp_cnt < 255) b_exp_cnt++;
      end
      b_ready = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) advance();
    rst_n = 1'b1;
    advance();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_a_valid: got %b want 0", a_out_valid); end
    n_checks++; if (a_out_onehot !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_a_word: got %h want 00", a_out_onehot); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_a_ready: got %b want 1", a_in_ready); end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_b_valid: got %b want 0", b_out_valid); end
    n_checks++; if (b_out_onehot !== 5'h1F) begin n_fail++; $display("[TB] FAIL reset_b_word: got %h want 1f", b_out_onehot); end
`ifdef DECODER_ERR_CNT_EN
    n_checks++; if (a_out_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_a_err: got %b want 0", a_out_err); end
    n_checks++; if (b_err_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_b_cnt: got %0d want 0", b_err_cnt); end
`endif
  endtask

  task automatic test_stream();
    logic [7:0] expw;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1; a_in_sel = 3'(i); a_in_en = 1'b1; a_out_ready = 1'b1;
      advance();
      expw = 8'd1 << i;
      n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_valid[%0d]: got %b want 1", i, a_out_valid); end
      n_checks++; if (a_out_onehot !== expw) begin n_fail++; $display("[TB] FAIL stream_word[%0d]: got %h want %h", i, a_out_onehot, expw); end
      n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_ready[%0d]: got %b want 1", i, a_in_ready); end
    end
    a_in_valid = 1'b0;
    advance();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_end_valid: got %b want 0", a_out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] tx[$];
    logic [7:0] rx[$];
    for (int c = 0; c < 16; c++) begin
      a_in_valid  = (c <= 8);
      a_in_sel    = 3'($urandom_range(0, 7));
      a_in_en     = 1'b1;
      a_out_ready = !(c >= 3 && c <= 6);
      if (a_in_valid && a_ready) tx.push_back(model_word(a_in_sel, a_in_en, 8, 1'b1));
      if (a_out_valid && a_out_ready) rx.push_back(a_out_onehot);
      advance();
      n_checks++; if (a_out_valid !== (qa.size() != 0)) begin n_fail++; $display("[TB] FAIL bp_valid[%0d]: got %b want %b", c, a_out_valid, qa.size() != 0); end
      if (qa.size() != 0) begin
        n_checks++; if (a_out_onehot !== qa[0]) begin n_fail++; $display("[TB] FAIL bp_word[%0d]: got %h want %h", c, a_out_onehot, qa[0]); end
      end
      if (c == 6) begin
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_stall_ready: got %b want 0", a_in_ready); end
        n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_stall_valid: got %b want 1", a_out_valid); end
      end
    end
    n_checks++; if (rx.size() != tx.size()) begin n_fail++; $display("[TB] FAIL bp_count: got %0d words want %0d", rx.size(), tx.size()); end
    for (int i = 0; i < rx.size() && i < tx.size(); i++) begin
      n_checks++; if (rx[i] !== tx[i]) begin n_fail++; $display("[TB] FAIL bp_order[%0d]: got %h want %h", i, rx[i], tx[i]); end
    end
  endtask

  task automatic test_enable_gate();
    idle_inputs();
    a_in_valid = 1'b1; a_in_sel = 3'd2; a_in_en = 1'b0;
    b_in_valid = 1'b1; b_in_sel = 3'd2; b_in_en = 1'b0;
    advance();
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL gate_a_valid: got %b want 1", a_out_valid); end
    n_checks++; if (a_out_onehot !== 8'h00) begin n_fail++; $display("[TB] FAIL gate_a_word: got %h want 00", a_out_onehot); end
    n_checks++; if (b_out_onehot !== 5'h1F) begin n_fail++; $display("[TB] FAIL gate_b_word: got %h want 1f", b_out_onehot); end
`ifdef DECODER_ERR_CNT_EN
    n_checks++; if (b_out_err !== 1'b0) begin n_fail++; $display("[TB] FAIL gate_b_err: got %b want 0", b_out_err); end
`endif
    idle_inputs();
    advance();
  endtask

`ifdef DECODER_ERR_CNT_EN
  task automatic test_out_of_range();
    idle_inputs();
    b_in_valid = 1'b1; b_in_sel = 3'd6; b_in_en = 1'b1;
    advance();
    n_checks++; if (b_out_onehot !== 5'h1F) begin n_fail++; $display("[TB] FAIL oor_word: got %h want 1f", b_out_onehot); end
    n_checks++; if (b_out_err !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_err: got %b want 1", b_out_err); end
    n_checks++; if (b_err_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL oor_cnt: got %0d want 1", b_err_cnt); end
    for (int i = 0; i < 300; i++) begin
      b_in_sel = 3'($urandom_range(5, 7));
      advance();
    end
    n_checks++; if (b_err_cnt !== 8'(b_exp_cnt)) begin n_fail++; $display("[TB] FAIL sat_cnt_model: got %0d want %0d", b_err_cnt, b_exp_cnt); end
    n_checks++; if (b_err_cnt !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_cnt: got %0d want 255", b_err_cnt); end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_ready: got %b want 1", b_in_ready); end
    idle_inputs();
    advance();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 250; c++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_sel    = 3'($urandom_range(0, 7));
      a_in_en     = ($urandom_range(0, 7) != 0);
      a_out_ready = ($urandom_range(0, 2) != 0);
      b_in_valid  = ($urandom_range(0, 1) != 0);
      b_in_sel    = 3'($urandom_range(0, 7));
      b_in_en     = ($urandom_range(0, 5) != 0);
      advance();
      n_checks++; if (a_in_ready !== a_ready) begin n_fail++; $display("[TB] FAIL rnd_a_ready[%0d]: got %b want %b", c, a_in_ready, a_ready); end
      n_checks++; if (a_out_valid !== (qa.size() != 0)) begin n_fail++; $display("[TB] FAIL rnd_a_valid[%0d]: got %b want %b", c, a_out_valid, qa.size() != 0); end
      if (qa.size() != 0) begin
        n_checks++; if (a_out_onehot !== qa[0]) begin n_fail++; $display("[TB] FAIL rnd_a_word[%0d]: got %h want %h", c, a_out_onehot, qa[0]); end
`ifdef DECODER_ERR_CNT_EN
        n_checks++; if (a_out_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_a_err[%0d]: got %b want 0", c, a_out_err); end
`endif
      end
      n_checks++; if (b_out_valid !== b_exp_valid) begin n_fail++; $display("[TB] FAIL rnd_b_valid[%0d]: got %b want %b", c, b_out_valid, b_exp_valid); end
      if (b_exp_valid) begin
        n_checks++; if (b_out_onehot !== b_exp_word) begin n_fail++; $display("[TB] FAIL rnd_b_word[%0d]: got %h want %h", c, b_out_onehot, b_exp_word); end
`ifdef DECODER_ERR_CNT_EN
        n_checks++; if (b_out_err !== b_exp_err) begin n_fail++; $display("[TB] FAIL rnd_b_err[%0d]: got %b want %b", c, b_out_err, b_exp_err); end
`endif
      end
`ifdef DECODER_ERR_CNT_EN
      n_checks++; if (b_err_cnt !== 8'(b_exp_cnt)) begin n_fail++; $display("[TB] FAIL rnd_b_cnt[%0d]: got %0d want %0d", c, b_err_cnt, b_exp_cnt); end
`endif
    end
  endtask

  task automatic test_reset_midflight();
    idle_inputs();
    repeat (3) advance();
    a_in_valid = 1'b1; a_in_sel = 3'd5; a_out_ready = 1'b0;
    advance();
    a_in_sel = 3'd6;
    advance();
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_full_ready: got %b want 0", a_in_ready); end
    n_checks++; if (a_out_onehot !== 8'h20) begin n_fail++; $display("[TB] FAIL mid_full_word: got %h want 20", a_out_onehot); end
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    advance();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_valid: got %b want 0", a_out_valid); end
    n_checks++; if (a_out_onehot !== 8'h00) begin n_fail++; $display("[TB] FAIL mid_rst_word: got %h want 00", a_out_onehot); end
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    repeat (2) begin
      advance();
      n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_stale_valid: got %b want 0", a_out_valid); end
    end
`ifdef DECODER_ERR_CNT_EN
    n_checks++; if (b_err_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL mid_rst_cnt: got %0d want 0", b_err_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_enable_gate();
`ifdef DECODER_ERR_CNT_EN
    test_out_of_range();
`endif
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
